fb_write_combiner: RTL and testbench

//  Framebuffer write stage directly downstream of the rasterizer/depth pipeline output (frag_out/color_out/frag_valid).

---
 rtl/fb_write_combiner.sv | 192 +++++++++++++++++++
 tb/tb_fb_write_combiner.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_combiner.sv
`default_nettype none
// ============================================================================
//  Module      : fb_write_combiner
//  Description : Framebuffer write stage. Clips fragments to the framebuffer,
//                converts X/Y to RGB565 byte addresses, coalesces horizontally
//                contiguous pixels into bursts and issues each burst as a
//                command followed by its write-data beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_write_combiner #(
    parameter int  FB_WIDTH  = 640,
    parameter int  FB_HEIGHT = 480,
    parameter int  ADDR_W    = 24,
    parameter int  MAX_BURST = 16,
    parameter int  TIMEOUT   = 32,
    localparam int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       frag_x,
    input  logic [15:0]       frag_y,
    input  logic [15:0]       frag_color,
    input  logic              frag_valid,
    output logic              frag_ready,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              flush,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [LEN_W-1:0]  mem_cmd_len,
    output logic [15:0]       mem_wdata,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic              mem_wlast,
    output logic              idle,
    output logic [15:0]       clip_count
);

    localparam int IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [15:0]      c_fb_width  = 16'(FB_WIDTH);
    localparam logic [15:0]      c_fb_height = 16'(FB_HEIGHT);
    localparam logic [LEN_W-1:0] c_max_len   = LEN_W'(MAX_BURST);
    localparam logic [TMR_W-1:0] c_timeout   = TMR_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CMD     = 2'd1,
        ST_DATA    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [ADDR_W-1:0] base_addr_q, base_addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       clip_count_q, clip_count_d;
    logic [15:0]       pix_buf_q [MAX_BURST];

    logic [ADDR_W-1:0] w_lin;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_clipped;
    logic              w_mergeable;
    logic              w_accept;
    logic              w_blocked;
    logic              w_buf_we;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_last_beat;

    // Fragment address, clip test and merge test against the open burst.
    // The address math is done in ADDR_W bits so it wraps modulo 2^ADDR_W.
    always_comb begin
        w_lin       = ADDR_W'(frag_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(frag_x);
        w_addr      = fb_base + (w_lin << 1);
        w_next_addr = base_addr_q + (ADDR_W'(count_q) << 1);
        w_clipped   = (frag_x >= c_fb_width) || (frag_y >= c_fb_height);
        w_mergeable = (count_q == '0) ||
                      ((w_addr == w_next_addr) && (count_q < c_max_len));
        frag_ready  = (state_q == ST_COLLECT) &&
                      (!frag_valid || w_clipped || w_mergeable);
        w_accept    = frag_valid && frag_ready;
        // An in-bounds pixel that cannot join the burst forces it out and waits.
        w_blocked   = (state_q == ST_COLLECT) && frag_valid &&
                      !w_clipped && !w_mergeable;
        w_wr_idx    = count_q[IDX_W-1:0];
        w_last_beat = (LEN_W'(idx_q) == (count_q - LEN_W'(1)));
    end

    // Next-state and handshake outputs for the collect / command / data sequence.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        timer_d       = timer_q;
        base_addr_d   = base_addr_q;
        idx_d         = idx_q;
        clip_count_d  = clip_count_q;
        w_buf_we      = 1'b0;
        mem_cmd_valid = 1'b0;
        mem_wvalid    = 1'b0;
        mem_wlast     = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                if (w_accept && w_clipped && (clip_count_q != 16'hFFFF)) begin
                    clip_count_d = clip_count_q + 16'd1;
                end

                if (w_accept && !w_clipped) begin
                    w_buf_we = 1'b1;
                    if (count_q == '0) begin
                        base_addr_d = w_addr;
                    end
                    count_d = count_q + LEN_W'(1);
                    timer_d = '0;
                end else if (!w_accept && (count_q != '0) && (timer_q != c_timeout)) begin
                    // Clipped accepts leave the timer alone; only true idle cycles age it.
                    timer_d = timer_q + TMR_W'(1);
                end

                // A full burst is detected on the registered count, so the
                // command appears one cycle after the completing accept.
                if ((count_d != '0) &&
                    ((count_q == c_max_len) || w_blocked || flush ||
                     (timer_q == c_timeout))) begin
                    state_d = ST_CMD;
                end
            end

            ST_CMD: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end

            ST_DATA: begin
                mem_wvalid = 1'b1;
                mem_wlast  = w_last_beat;
                if (mem_wready) begin
                    if (w_last_beat) begin
                        state_d = ST_COLLECT;
                        count_d = '0;
                        timer_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // Control registers; reset abandons any buffered pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_COLLECT;
            count_q      <= '0;
            timer_q      <= '0;
            base_addr_q  <= '0;
            idx_q        <= '0;
            clip_count_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            base_addr_q  <= base_addr_d;
            idx_q        <= idx_d;
            clip_count_q <= clip_count_d;
        end
    end

    // Pixel storage; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            pix_buf_q[w_wr_idx] <= frag_color;
        end
    end

    assign mem_cmd_addr = base_addr_q;
    assign mem_cmd_len  = count_q;
    assign mem_wdata    = pix_buf_q[idx_q];
    assign idle         = (state_q == ST_COLLECT) && (count_q == '0);
    assign clip_count   = clip_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_combiner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_write_combiner
//  Description : Scoreboard testbench for fb_write_combiner with directed
//                fragment streams and hand-computed burst expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_write_combiner;

    localparam int AW = 24;
    localparam int LW = 5;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [15:0]   frag_x = '0;
    logic [15:0]   frag_y = '0;
    logic [15:0]   frag_color = '0;
    logic          frag_valid = 1'b0;
    logic          frag_ready;
    logic [AW-1:0] fb_base = '0;
    logic          flush = 1'b0;
    logic          mem_cmd_valid;
    logic          mem_cmd_ready = 1'b1;
    logic [AW-1:0] mem_cmd_addr;
    logic [LW-1:0] mem_cmd_len;
    logic [15:0]   mem_wdata;
    logic          mem_wvalid;
    logic          mem_wready = 1'b1;
    logic          mem_wlast;
    logic          idle;
    logic [15:0]   clip_count;

    fb_write_combiner dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frag_x        (frag_x),
        .frag_y        (frag_y),
        .frag_color    (frag_color),
        .frag_valid    (frag_valid),
        .frag_ready    (frag_ready),
        .fb_base       (fb_base),
        .flush         (flush),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_len   (mem_cmd_len),
        .mem_wdata     (mem_wdata),
        .mem_wvalid    (mem_wvalid),
        .mem_wready    (mem_wready),
        .mem_wlast     (mem_wlast),
        .idle          (idle),
        .clip_count    (clip_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } cmd_t;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } beat_t;

    cmd_t  exp_cmd_q[$];
    beat_t exp_beat_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_acc   = 0;
    bit tog_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Ready toggling for the stalled-data scenario.
    always @(posedge clk) begin
        #1;
        if (tog_en) mem_wready = ~mem_wready;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic expect_cmd(input logic [AW-1:0] addr, input int len);
        cmd_t c;
        c.addr = addr;
        c.len  = LW'(len);
        exp_cmd_q.push_back(c);
    endtask

    task automatic expect_beat(input logic [15:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        exp_beat_q.push_back(b);
    endtask

    // Present one fragment and hold it until accepted; waits = stalled cycles.
    task automatic send(input int x, input int y, input logic [15:0] c, output int waits);
        frag_x     = 16'(x);
        frag_y     = 16'(y);
        frag_color = c;
        frag_valid = 1'b1;
        waits      = 0;
        @(negedge clk);
        while (!frag_ready && waits < 400) begin
            waits++;
            @(negedge clk);
        end
        if (!frag_ready) fail_now("send_accept");
        @(posedge clk);
        #1;
        frag_valid = 1'b0;
        t_acc      = cyc;
    endtask

    task automatic wait_cmd(output int dt);
        int n = 0;
        @(negedge clk);
        while (!mem_cmd_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!mem_cmd_valid) fail_now("wait_cmd");
        dt = cyc - t_acc;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!idle && n < 400) begin
            n++;
            @(negedge clk);
        end
        if (!idle) fail_now("wait_idle");
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // Monitor: compare every command and data handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_cmd_valid && mem_cmd_ready) begin
                if (exp_cmd_q.size() == 0) begin
                    fail_now("cmd_unexpected");
                end else begin
                    cmd_t e;
                    e = exp_cmd_q.pop_front();
                    check("cmd_addr", 64'(mem_cmd_addr), 64'(e.addr));
                    check("cmd_len", 64'(mem_cmd_len), 64'(e.len));
                end
            end
            if (mem_wvalid && mem_wready) begin
                if (exp_beat_q.size() == 0) begin
                    fail_now("beat_unexpected");
                end else begin
                    beat_t b;
                    b = exp_beat_q.pop_front();
                    check("beat_data", 64'(mem_wdata), 64'(b.data));
                    check("beat_last", 64'(mem_wlast), 64'(b.last));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int tot;
        int dt;

        // Reset values, asynchronous assertion.
        #1 rst_n = 1'b0;
        #2;
        check("rst_cmd_valid", 64'(mem_cmd_valid), 64'd0);
        check("rst_wvalid", 64'(mem_wvalid), 64'd0);
        check("rst_wlast", 64'(mem_wlast), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_clip_count", 64'(clip_count), 64'd0);
        check("rst_frag_ready", 64'(frag_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: 16 contiguous pixels, one full burst.
        fb_base = 24'h001000;
        expect_cmd(24'h001000, 16);
        for (int i = 0; i < 16; i++) expect_beat(16'hA000 + 16'(i), (i == 15));
        tot = 0;
        for (int i = 0; i < 16; i++) begin
            send(i, 0, 16'hA000 + 16'(i), w);
            tot += w;
        end
        check("t1_no_stall", 64'(tot), 64'd0);
        wait_cmd(dt);
        check("t1_cmd_latency", 64'(dt), 64'd1);
        wait_idle();

        // T2: non-contiguous second pixel is held until the first burst drains.
        fb_base = '0;
        expect_cmd(24'h000A0A, 1);
        expect_beat(16'h1234, 1'b1);
        expect_cmd(24'h000AC8, 1);
        expect_beat(16'h5678, 1'b1);
        send(5, 2, 16'h1234, w);
        send(100, 2, 16'h5678, w);
        check("t2_held_cycles", 64'(w), 64'd3);
        wait_cmd(dt);
        check("t2_timeout_latency", 64'(dt), 64'(TO + 1));
        wait_idle();

        // T3: out-of-bounds fragments are accepted and dropped.
        send(640, 0, 16'hDEAD, w);
        check("t3_clip_x_no_stall", 64'(w), 64'd0);
        check("t3_idle_after_x", 64'(idle), 64'd1);
        send(0, 480, 16'hBEEF, w);
        check("t3_clip_count", 64'(clip_count), 64'd2);
        repeat (40) @(posedge clk);
        #1;
        check("t3_idle_after_wait", 64'(idle), 64'd1);

        // T4: partial burst flushed by timeout, then by an explicit flush.
        fb_base = 24'h000100;
        expect_cmd(24'h000628, 3);
        for (int i = 0; i < 3; i++) expect_beat(16'h0C00 + 16'(i), (i == 2));
        for (int i = 0; i < 3; i++) send(20 + i, 1, 16'h0C00 + 16'(i), w);
        wait_cmd(dt);
        check("t4_timeout_latency", 64'(dt), 64'(TO + 1));
        wait_idle();
        expect_cmd(24'h00063C, 3);
        for (int i = 0; i < 3; i++) expect_beat(16'h0D00 + 16'(i), (i == 2));
        for (int i = 0; i < 3; i++) send(30 + i, 1, 16'h0D00 + 16'(i), w);
        pulse_flush();
        wait_cmd(dt);
        check("t4_flush_latency", 64'(dt), 64'd1);
        wait_idle();

        // T5: full burst with command back-pressure and toggling write ready.
        fb_base       = 24'h020000;
        mem_cmd_ready = 1'b0;
        tog_en        = 1'b1;
        expect_cmd(24'h020F00, 16);
        for (int i = 0; i < 16; i++) expect_beat(16'h5000 + 16'(i), (i == 15));
        expect_cmd(24'h021400, 1);
        expect_beat(16'h7777, 1'b1);
        for (int i = 0; i < 16; i++) send(i, 3, 16'h5000 + 16'(i), w);
        fork
            send(0, 4, 16'h7777, w);
            begin
                int d5;
                wait_cmd(d5);
                repeat (10) @(posedge clk);
                #1 mem_cmd_ready = 1'b1;
            end
        join
        check("t5_pending_stalled", 64'(w >= 27), 64'd1);
        wait_idle();
        tog_en = 1'b0;
        @(posedge clk);
        #2 mem_wready = 1'b1;

        // T6: reset asserted in the middle of the data phase.
        fb_base = '0;
        expect_cmd(24'h001900, 8);
        for (int i = 0; i < 8; i++) expect_beat(16'h6000 + 16'(i), (i == 7));
        for (int i = 0; i < 8; i++) send(i, 5, 16'h6000 + 16'(i), w);
        pulse_flush();
        begin
            int n = 0;
            @(negedge clk);
            while (!mem_wvalid && n < 50) begin
                n++;
                @(negedge clk);
            end
            if (!mem_wvalid) fail_now("t6_wait_data");
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_wvalid", 64'(mem_wvalid), 64'd0);
        check("t6_idle", 64'(idle), 64'd1);
        check("t6_clip_count", 64'(clip_count), 64'd0);
        check("t6_cmd_valid", 64'(mem_cmd_valid), 64'd0);
        check("t6_beats_left", 64'(exp_beat_q.size()), 64'd6);
        exp_beat_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_cmd(24'h000514, 1);
        expect_beat(16'h4321, 1'b1);
        send(10, 1, 16'h4321, w);
        pulse_flush();
        wait_cmd(dt);
        check("t6_fresh_latency", 64'(dt), 64'd1);
        wait_idle();

        repeat (5) @(posedge clk);
        #1;
        check("end_cmd_queue_empty", 64'(exp_cmd_q.size()), 64'd0);
        check("end_beat_queue_empty", 64'(exp_beat_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
